// File: rtl/fft_frame_ctrl.sv
// Frame collector, chain sequencer and result reorder for the 16-point FFT chain.
// Define FFT_BITREV_EN to reorder captured results into natural order; otherwise fft_d is raw bit-reversed.
module fft_frame_ctrl #(
    parameter int N    = 16,
    parameter int DW   = 16,
    parameter int PIPE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DW-1:0]       fir_d,
    input  logic                fir_valid,
    output logic [N*2*DW-1:0]   frame_out,
    output logic                frame_vld,
    output logic [PIPE-1:0]     stage_en,
    input  logic [N*2*DW-1:0]   frame_in,
    output logic [N*2*DW-1:0]   fft_d,
    output logic                fft_valid,
    output logic                done
);

    localparam int AW = $clog2(N);
    localparam int WW = 2 * DW;
    localparam int FW = N * WW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_wr_cnt;
    logic [DW-1:0]    r_buf [N];
    logic [FW-1:0]    r_frame_out;
    logic             r_frame_vld;
    logic [PIPE-1:0]  r_p;
    logic [FW-1:0]    r_fft_d;
    logic             r_fft_valid;

    logic             w_accept;
    logic             w_last;
    logic [FW-1:0]    w_frame;
    logic [FW-1:0]    w_reord;
    logic [PIPE-1:0]  w_stage_en;
    logic             w_done;

    function automatic logic [3:0] bitrev4(input logic [3:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

    assign w_accept = fir_valid && (r_state != S_DONE);
    assign w_last   = w_accept && (r_wr_cnt == AW'(N - 1));

    // Word N-1 comes straight from the input so a launch never waits on the buffer write.
    always_comb begin
        w_frame = '0;
        for (int unsigned k = 0; k < N - 1; k++) begin
            w_frame[k*WW +: WW] = {r_buf[k], {DW{1'b0}}};
        end
        w_frame[(N-1)*WW +: WW] = {fir_d, {DW{1'b0}}};
    end

    always_comb begin
        w_reord = '0;
`ifdef FFT_BITREV_EN
        for (int unsigned k = 0; k < N; k++) begin
            w_reord[int'(bitrev4(4'(k)))*WW +: WW] = frame_in[k*WW +: WW];
        end
`else
        w_reord = frame_in;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_cnt <= '0;
            for (int unsigned k = 0; k < N; k++) begin
                r_buf[k] <= '0;
            end
        end else if (w_accept) begin
            r_buf[r_wr_cnt] <= fir_d;
            r_wr_cnt        <= r_wr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_out <= '0;
            r_frame_vld <= 1'b0;
        end else begin
            r_frame_vld <= w_last;
            if (w_last) begin
                r_frame_out <= w_frame;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p <= '0;
        end else begin
            r_p[0] <= r_frame_vld;
            for (int unsigned i = 1; i < PIPE; i++) begin
                r_p[i] <= r_p[i-1];
            end
        end
    end

    always_comb begin
        w_stage_en    = '0;
        w_stage_en[0] = r_frame_vld;
        for (int unsigned i = 1; i < PIPE; i++) begin
            w_stage_en[i] = r_p[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fft_d     <= '0;
            r_fft_valid <= 1'b0;
        end else begin
            r_fft_valid <= r_p[PIPE-1];
            if (r_p[PIPE-1]) begin
                r_fft_d <= w_reord;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DRAIN waits for both the launch pulse and the whole pipe-valid chain to empty.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fir_valid) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (!fir_valid && (r_wr_cnt == '0)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fir_valid) begin
                    w_state_nxt = S_FILL;
                end else if ((r_p == '0) && !r_frame_vld) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign frame_out = r_frame_out;
    assign frame_vld = r_frame_vld;
    assign stage_en  = w_stage_en;
    assign fft_d     = r_fft_d;
    assign fft_valid = r_fft_valid;
    assign done      = w_done;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Randomized bench for fft_frame_ctrl with an echo stub chain and a stream-level reference model.
module tb_fft_frame_ctrl;

    localparam int N    = 16;
    localparam int DW   = 16;
    localparam int PIPE = 4;
    localparam int WW   = 2 * DW;
    localparam int FW   = N * WW;

`ifdef FFT_BITREV_EN
    localparam bit REORDER = 1'b1;
`else
    localparam bit REORDER = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   fir_d;
    logic            fir_valid;
    logic [FW-1:0]   frame_out;
    logic            frame_vld;
    logic [PIPE-1:0] stage_en;
    logic [FW-1:0]   frame_in;
    logic [FW-1:0]   fft_d;
    logic            fft_valid;
    logic            done;

    always #5 clk = ~clk;

    fft_frame_ctrl #(.N(N), .DW(DW), .PIPE(PIPE)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .fir_d     (fir_d),
        .fir_valid (fir_valid),
        .frame_out (frame_out),
        .frame_vld (frame_vld),
        .stage_en  (stage_en),
        .frame_in  (frame_in),
        .fft_d     (fft_d),
        .fft_valid (fft_valid),
        .done      (done)
    );

    // Stub chain: frame_out delayed by PIPE registers, imag halves overwritten by a known mask.
    logic [FW-1:0] dly [PIPE];
    logic [FW-1:0] imag_mask;

    always @(posedge clk) begin
        dly[0] <= frame_out;
        for (int i = 1; i < PIPE; i++) dly[i] <= dly[i-1];
    end
    assign frame_in = dly[PIPE-1] ^ imag_mask;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state: samples of the current frame, last launch edge, expected held outputs.
    logic [DW-1:0] smp [N];
    int            cnt;
    int            t;
    int            last_launch;
    bit            have_launch;
    bit            any_since;
    bit            exp_done;
    logic [FW-1:0] exp_frame;
    logic [FW-1:0] exp_fft;
    int            n_fv;
    int            n_done;

    function automatic int brev(input int k);
        return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
    endfunction

    task automatic model_reset();
        cnt         = 0;
        have_launch = 1'b0;
        any_since   = 1'b0;
        exp_done    = 1'b0;
        last_launch = -1000;
        exp_frame   = '0;
        exp_fft     = '0;
    endtask

    task automatic set_mask(input bit zero);
        imag_mask = '0;
        if (!zero) begin
            for (int k = 0; k < N; k++) imag_mask[k*WW +: DW] = DW'($urandom);
        end
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d);
        int              dd;
        logic [FW-1:0]   chain;
        logic [PIPE-1:0] exp_en;
        fir_valid = v;
        fir_d     = d;
        @(posedge clk);
        #1;
        t++;
        // A sample offered during the done cycle is dropped.
        if (v && !exp_done) begin
            smp[cnt] = d;
            cnt++;
            if (cnt == N) begin
                for (int k = 0; k < N; k++) exp_frame[k*WW +: WW] = {smp[k], 16'h0000};
                last_launch = t;
                have_launch = 1'b1;
                any_since   = 1'b0;
                cnt         = 0;
            end else begin
                any_since = 1'b1;
            end
        end
        dd = t - last_launch;
        if (dd == PIPE + 1) begin
            chain = exp_frame ^ imag_mask;
            for (int k = 0; k < N; k++)
                exp_fft[(REORDER ? brev(k) : k)*WW +: WW] = chain[k*WW +: WW];
        end
        exp_done = have_launch && !any_since && (dd == PIPE + 2);
        if (exp_done) have_launch = 1'b0;
        for (int i = 0; i < PIPE; i++) exp_en[i] = (dd == i);

        check_eq("frame_vld", FW'(frame_vld), FW'(dd == 0));
        check_eq("frame_out", frame_out, exp_frame);
        check_eq("stage_en",  FW'(stage_en), FW'(exp_en));
        check_eq("fft_valid", FW'(fft_valid), FW'(dd == PIPE + 1));
        check_eq("fft_d",     fft_d, exp_fft);
        check_eq("done",      FW'(done), FW'(exp_done));
        if (fft_valid) n_fv++;
        if (done) n_done++;
    endtask

    task automatic samples(input int n, input bit rnd, input int base);
        for (int i = 0; i < n; i++) step(1'b1, rnd ? DW'($urandom) : DW'(base + i));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, DW'($urandom));
    endtask

    task automatic check_counts(input string tag, input int fv, input int dn);
        check_eq({tag, "_fv_count"},   FW'(n_fv), FW'(fv));
        check_eq({tag, "_done_count"}, FW'(n_done), FW'(dn));
        n_fv   = 0;
        n_done = 0;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_frame_vld"}, FW'(frame_vld), '0);
        check_eq({tag, "_stage_en"},  FW'(stage_en), '0);
        check_eq({tag, "_fft_valid"}, FW'(fft_valid), '0);
        check_eq({tag, "_done"},      FW'(done), '0);
        check_eq({tag, "_frame_out"}, frame_out, '0);
        check_eq({tag, "_fft_d"},     fft_d, '0);
    endtask

    initial begin
        int wi;
        rst       = 1'b0;
        fir_valid = 1'b0;
        fir_d     = '0;
        t         = 0;
        n_fv      = 0;
        n_done    = 0;
        set_mask(1'b1);
        model_reset();
        #2;
        check_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // Ramp 1..16 through a pure echo chain.
        samples(16, 1'b0, 1);
        idle(12);
        check_counts("ramp", 1, 1);
        wi = REORDER ? 8 : 1;
        check_eq("ramp_word", FW'(fft_d[wi*WW +: WW]), FW'(32'h00020000));

        // Two back-to-back frames.
        set_mask(1'b0);
        samples(32, 1'b1, 0);
        idle(12);
        check_counts("b2b", 2, 1);

        // Gap of 7 idle cycles after sample 5.
        samples(6, 1'b1, 0);
        idle(7);
        samples(10, 1'b1, 0);
        idle(12);
        check_counts("gap", 1, 1);

        // Sample offered during the done cycle must be dropped.
        set_mask(1'b0);
        samples(16, 1'b1, 0);
        idle(PIPE + 2);
        step(1'b1, 16'hDEAD);
        samples(16, 1'b1, 0);
        idle(12);
        check_counts("donedrop", 2, 2);

        // Partial frame stalls in FILL, then completes.
        samples(5, 1'b1, 0);
        idle(30);
        check_counts("partial", 0, 0);
        samples(11, 1'b1, 0);
        idle(12);
        check_counts("partial_end", 1, 1);

        // Reset two cycles after launch discards the in-flight frame.
        samples(16, 1'b1, 0);
        idle(2);
        #2 rst = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        n_fv   = 0;
        n_done = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(12);
        check_counts("midrst_quiet", 0, 0);
        set_mask(1'b0);
        samples(16, 1'b1, 0);
        idle(12);
        check_counts("midrst_next", 1, 1);

        // Random bursts and gaps.
        for (int b = 0; b < 25; b++) begin
            int len;
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) step(($urandom_range(0, 9) != 0), DW'($urandom));
            idle($urandom_range(0, 12));
        end
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Front-end controller for the 16-point radix-2 DIF FFT chain (four combinational butterfly stages with pipeline registers between them).
- Collects the serial FIR sample stream into 16-sample frames and launches each frame into the chain.
- Sequences the chain's register enables, captures the chain result, reorders it from bit-reversed to natural order, and signals frame-valid and end-of-stream.

Parameters:
- N, 16, samples per frame; fixed at 16, the index width is 4.
- DW, 16, sample width; also the width of each real/imag half.
- PIPE, 4, number of registered stages in the downstream FFT chain; legal range 1..8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- fir_d  in  DW  FIR sample, signed fixed point.
- fir_valid  in  1  fir_d is valid this cycle.
- frame_out  out  N*2*DW  frame to the chain; word k = [64k... no: word k occupies bits [32k+31:32k], packed {real, imag}.
- frame_vld  out  1  frame_out is valid; single-cycle pulse.
- stage_en  out  PIPE  per-stage register enable for the chain.
- frame_in  in  N*2*DW  chain result, in bit-reversed order, same packing as frame_out.
- fft_d  out  N*2*DW  result in natural order, same packing.
- fft_valid  out  1  fft_d updated; single-cycle pulse.
- done  out  1  end-of-stream; single-cycle pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0: frame_out, frame_vld, stage_en, fft_d, fft_valid, done.
  - wr_cnt=0, sample buffer cleared, pipe-valid shift register p[PIPE-1:0]=0, FSM in IDLE.
  - Reset asserted mid-frame or mid-flight discards all data; no fft_valid or done follows.
- Sample capture:
  - On every edge with fir_valid=1 (in any state except DONE), store buf[wr_cnt] = {fir_d, 16'h0000} and increment wr_cnt. wr_cnt wraps 15 to 0.
  - No back-pressure exists. A frame takes at least 16 cycles to fill, which is always at least PIPE+2, so no overlap stall is needed.
- Launch:
  - On the edge that accepts sample 15, register frame_out from buf[0..14] plus the incoming sample as word 15, and set frame_vld=1 for exactly one cycle.
  - frame_out holds its value until the next launch.
- Chain sequencing:
  - p[0] <= frame_vld; p[i] <= p[i-1].
  - stage_en[0] = frame_vld; stage_en[i] = p[i-1] for i≥1. Enables are combinational from these registers.
- Capture:
  - When p[PIPE-1]=1, register fft_d word bitrev4(k) = frame_in word k, and pulse fft_valid for one cycle.
  - Latency: fft_valid is high in the cycle following the (PIPE+1)th rising edge after the edge that accepted sample 15. With PIPE=4 this is 5 edges.
  - fft_d holds its value until the next capture.
- FSM:
  - IDLE: on fir_valid=1, capture the sample and go to FILL.
  - FILL: if fir_valid=0 and wr_cnt≠0, stay in FILL; gaps inside a frame are tolerated. If fir_valid=0 and wr_cnt=0, go to DRAIN.
  - DRAIN: if fir_valid=1, capture the sample and return to FILL (no done). Else, when p==0 and no capture is pending, go to DONE.
  - DONE: done=1 for one cycle, then IDLE. fir_valid is ignored in this cycle.
- Boundary cases:
  - If fir_valid=1 on the launch edge, sample 0 of the next frame is written at the same edge; the launch uses the merged word 15, not the buffer.
  - A stream ending with wr_cnt≠0 keeps the FSM in FILL indefinitely. The partial frame is never launched and done is not raised.
- Arithmetic: none in this block. The imag half is forced to 0 on input, and frame_in is passed through unmodified.

Optional Feature:
- FFT_BITREV_EN:
  - Defined: capture applies the bitrev4 reorder as described above (natural-order fft_d).
  - Undefined: fft_d word k = frame_in word k (raw bit-reversed order). This saves the permutation mux; the downstream consumer reorders.
  - Latency and handshakes are identical in both builds.

Test Plan:
- Stub chain that echoes frame_out delayed by PIPE registers; samples 0x0001..0x0010 → fft_valid 5 edges after the 16th sample. Word bitrev(k) = {k+1, 0x0000}; e.g. word 8 = 0x00020000. With FFT_BITREV_EN undefined, word 1 = 0x00020000.
- Real chain, 16 samples of 0x0100 → fft_d word 0 = 0x10000000, words 1..15 = 0; exactly one fft_valid.
- Real chain, impulse 0x0100 then 15 zeros → all 16 words = 0x01000000.
- 32 back-to-back samples then fir_valid=0 → two fft_valid pulses 16 cycles apart. Then done=1 for one cycle after the second pulse; FSM back in IDLE.
- Gap of 7 idle cycles after sample 5 → no done; the frame completes normally when sampling resumes.
- rst=0 asserted two cycles after launch → frame_vld, stage_en, fft_valid and done are immediately 0; no fft_valid after release; the next 16 samples produce a correct frame.
